// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, port indices and timeout default for the memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
    localparam logic PORT_MEM    = 1'b0;
    localparam logic PORT_IF     = 1'b1;
    localparam int   TIMEOUT_DEF = 63;
endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: two-way round-robin pick; on a tie the port not granted last wins
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant
);
    assign grant = (&req) ? ~last : req[PORT_IF];
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one SRAM controller between the MEM-stage port and the fetch/refill port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_r_en,
    input  logic              p0_w_en,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic [31:0]       p0_rdata,
    output logic              p0_ready,
    input  logic              p1_r_en,
    input  logic              p1_w_en,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic [31:0]       p1_rdata,
    output logic              p1_ready,
    output logic              sc_r_en,
    output logic              sc_w_en,
    output logic [ADDR_W-1:0] sc_addr,
    output logic [31:0]       sc_wdata,
    input  logic [31:0]       sc_rdata,
    input  logic              sc_ready,
    output logic              err
);
    localparam int CW = $clog2(TIMEOUT + 2);
    state_t        state, state_nx;
    logic [1:0]    req;
    logic          grant, last, port, dir_w, tmo, done;
    logic [CW-1:0] cnt;
    assign req  = {p1_r_en | p1_w_en, p0_r_en | p0_w_en};
    assign tmo  = cnt == CW'(TIMEOUT);
    // a completion or an abort both end the access in this cycle
    assign done = state == BUSY && (sc_ready || tmo);
    mem_arb_rr u_rr (
        .req   (req),
        .last  (last),
        .grant (grant)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    always_comb
        state_nx = state == IDLE ? (|req ? BUSY : IDLE) :
                   state == BUSY ? (done ? RELEASE : BUSY) : IDLE;
    always_comb begin
        sc_r_en  = state == BUSY && !dir_w;
        sc_w_en  = state == BUSY && dir_w;
        p0_ready = !req[PORT_MEM] || (done && port == PORT_MEM);
        p1_ready = !req[PORT_IF] || (done && port == PORT_IF);
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            last     <= PORT_IF;
            port     <= PORT_MEM;
            dir_w    <= 1'b0;
            cnt      <= '0;
            sc_addr  <= '0;
            sc_wdata <= '0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            err      <= 1'b0;
        end else if (state == IDLE && |req) begin
            last     <= grant;
            port     <= grant;
            cnt      <= '0;
            dir_w    <= grant ? p1_w_en : p0_w_en;
            sc_addr  <= grant ? p1_addr : p0_addr;
            sc_wdata <= grant ? p1_wdata : p0_wdata;
        end else if (state == BUSY) begin
            if (sc_ready && !dir_w && port == PORT_MEM) p0_rdata <= sc_rdata;
            if (sc_ready && !dir_w && port == PORT_IF) p1_rdata <= sc_rdata;
            if (!sc_ready && tmo) err <= 1'b1;
            if (!done) cnt <= cnt + CW'(1);
        end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner sequences and a random run against a timeline model
module tb_mem_arbiter;
    localparam int TMO = 63;
    typedef struct {
        logic        port;
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata_in;
        int          lat;
        logic        exp_w;
        logic [31:0] exp_rd0;
        logic [31:0] exp_rd1;
    } row_t;
    logic        clk = 0, rst = 0;
    logic        p0_r_en, p0_w_en, p1_r_en, p1_w_en, sc_ready;
    logic [31:0] p0_addr = 0, p1_addr = 0, p0_wdata = 0, p1_wdata = 0, sc_rdata = 0;
    logic [31:0] p0_rdata, p1_rdata, sc_addr, sc_wdata;
    logic        p0_ready, p1_ready, sc_r_en, sc_w_en, err;
    int          vecs = 0, errs = 0;
    row_t        tbl [6];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_r_en(p0_r_en), .p0_w_en(p0_w_en), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_ready(p0_ready),
        .p1_r_en(p1_r_en), .p1_w_en(p1_w_en), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_ready(p1_ready),
        .sc_r_en(sc_r_en), .sc_w_en(sc_w_en), .sc_addr(sc_addr), .sc_wdata(sc_wdata),
        .sc_rdata(sc_rdata), .sc_ready(sc_ready), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chkb(input string name, input logic act, input logic exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p0_r_en = 0; p0_w_en = 0; p1_r_en = 0; p1_w_en = 0; sc_ready = 0;
    endtask

    task automatic set_port(input logic p, input logic r, input logic w,
                            input logic [31:0] a, input logic [31:0] d);
        if (p) begin p1_r_en = r; p1_w_en = w; p1_addr = a; p1_wdata = d; end
        else   begin p0_r_en = r; p0_w_en = w; p0_addr = a; p0_wdata = d; end
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        @(negedge clk);
        chkb("rst sc_r_en", sc_r_en, 0);
        chkb("rst sc_w_en", sc_w_en, 0);
        chkw("rst sc_addr", sc_addr, 0);
        chkw("rst sc_wdata", sc_wdata, 0);
        chkw("rst p0_rdata", p0_rdata, 0);
        chkw("rst p1_rdata", p1_rdata, 0);
        chkb("rst err", err, 0);
        chkb("rst ready", p0_ready && p1_ready, 1);
        tick();
        rst = 1;
    endtask

    // one access on one port with the controller answering in BUSY cycle t.lat
    task automatic run_row(input row_t t);
        int   busy = 0, ready_at = -1;
        logic other_ok = 1, bus_ok = 1;
        idle_inputs();
        set_port(t.port, t.r, t.w, t.addr, t.wdata);
        for (int c = 0; c < 12; c++) begin
            if (sc_r_en || sc_w_en) busy++;
            sc_ready = (sc_r_en || sc_w_en) && busy == t.lat;
            sc_rdata = sc_ready ? t.rdata_in : $urandom;
            @(negedge clk);
            if (!(t.port ? p0_ready : p1_ready)) other_ok = 0;
            if ((sc_r_en || sc_w_en) && (sc_w_en !== t.exp_w || sc_r_en !== !t.exp_w ||
                sc_addr !== t.addr || sc_wdata !== t.wdata)) bus_ok = 0;
            if (ready_at < 0 && (t.port ? p1_ready : p0_ready)) ready_at = c;
            tick();
            if (ready_at >= 0) idle_inputs();
        end
        chkw("row ready cycle", ready_at, t.lat);
        chkw("row busy cycles", busy, t.lat);
        chkb("row other port ready", other_ok, 1);
        chkb("row bus signals", bus_ok, 1);
        chkw("row p0_rdata", p0_rdata, t.exp_rd0);
        chkw("row p1_rdata", p1_rdata, t.exp_rd1);
    endtask

    task automatic seq_alternate();
        int   busy = 0, n = 0, rdy0 = 0, rdy1 = 0;
        int   ord [4] = '{-1, -1, -1, -1};
        logic ovl = 0, dir_bad = 0;
        idle_inputs();
        set_port(0, 0, 1, 32'h100, 32'h11111111);
        set_port(1, 1, 0, 32'h200, 32'h0);
        for (int c = 0; c < 16; c++) begin
            busy = (sc_r_en || sc_w_en) ? busy + 1 : 0;
            if (busy == 1 && n < 4) begin
                ord[n] = (sc_addr == 32'h200) ? 1 : 0;
                n++;
            end
            sc_ready = busy == 2;
            sc_rdata = $urandom;
            @(negedge clk);
            if (sc_r_en && sc_w_en) ovl = 1;
            if ((sc_r_en || sc_w_en) && sc_w_en !== (sc_addr == 32'h100)) dir_bad = 1;
            rdy0 += int'(p0_ready);
            rdy1 += int'(p1_ready);
            tick();
        end
        idle_inputs();
        chkw("alt grants", n, 4);
        for (int i = 0; i < 4; i++) chkw("alt grant order", ord[i], i % 2);
        chkb("alt enable overlap", ovl, 0);
        chkb("alt direction", dir_bad, 0);
        chkw("alt p0 ready pulses", rdy0, 2);
        chkw("alt p1 ready pulses", rdy1, 2);
    endtask

    task automatic seq_timeout();
        int   busy = 0, ready_at = -1;
        logic err_early = 0;
        idle_inputs();
        set_port(1, 1, 0, 32'h300, 32'h0);
        for (int c = 0; c < TMO + 10; c++) begin
            if (sc_r_en || sc_w_en) busy++;
            sc_ready = 0;
            sc_rdata = $urandom;
            @(negedge clk);
            if (ready_at < 0 && err) err_early = 1;
            if (ready_at < 0 && p1_ready) ready_at = busy;
            tick();
            if (ready_at >= 0) begin
                idle_inputs();
                break;
            end
        end
        sc_ready = 1;
        sc_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chkb("tmo release bus idle", sc_r_en || sc_w_en, 0);
        tick();
        sc_ready = 0;
        chkw("tmo ready busy cycle", ready_at, TMO + 1);
        chkb("tmo err early", err_early, 0);
        chkb("tmo err set", err, 1);
        chkw("tmo p1_rdata kept", p1_rdata, 32'hCAFEF00D);
    endtask

    task automatic seq_midreset();
        idle_inputs();
        set_port(0, 1, 0, 32'h500, 32'h0);
        tick();
        tick();
        chkb("mid busy before rst", sc_r_en, 1);
        rst = 0;
        #1;
        chkb("mid sc_r_en", sc_r_en, 0);
        chkb("mid sc_w_en", sc_w_en, 0);
        chkw("mid sc_addr", sc_addr, 0);
        chkw("mid sc_wdata", sc_wdata, 0);
        chkw("mid p0_rdata", p0_rdata, 0);
        chkw("mid p1_rdata", p1_rdata, 0);
        chkb("mid err", err, 0);
        idle_inputs();
        tick();
        rst = 1;
        @(negedge clk);
        chkb("mid not resumed", sc_r_en || sc_w_en, 0);
        tick();
        set_port(0, 1, 0, 32'h600, 32'h0);
        set_port(1, 1, 0, 32'h700, 32'h0);
        tick();
        @(negedge clk);
        chkw("mid tie goes p0", sc_addr, 32'h600);
        chkb("mid tie read", sc_r_en, 1);
    endtask

    // model: an access granted at cycle g with controller answer after k BUSY cycles
    // occupies g+1..g+k, releases at g+k+1 and the arbiter is free again at g+k+2
    task automatic rand_phase(input int n);
        int          free_at = 0, grant_cyc = -1, done_cyc = 0, owner = -1, mlast = 1, kind;
        logic        acc_w = 0, hang = 0, exp_err = 0, busy;
        logic [31:0] acc_addr = 0, acc_wd = 0, prev_addr = 0, prev_wd = 0, ea, ed;
        logic [31:0] exp_rd [2] = '{0, 0};
        logic [31:0] ra [2] = '{0, 0};
        logic [31:0] rd [2] = '{0, 0};
        logic        pend [2] = '{0, 0};
        logic        rr [2] = '{0, 0};
        logic        rw [2] = '{0, 0};
        logic        erdy [2] = '{0, 0};
        for (int cyc = 0; cyc < n; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (pend[p] && erdy[p]) pend[p] = 0;
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 2);
                    pend[p] = 1; rr[p] = kind != 1; rw[p] = kind != 0;
                    ra[p] = $urandom; rd[p] = $urandom;
                end
            end
            p0_r_en = pend[0] && rr[0]; p0_w_en = pend[0] && rw[0]; p0_addr = ra[0]; p0_wdata = rd[0];
            p1_r_en = pend[1] && rr[1]; p1_w_en = pend[1] && rw[1]; p1_addr = ra[1]; p1_wdata = rd[1];
            if (owner < 0 && cyc >= free_at && (pend[0] || pend[1])) begin
                owner = (pend[0] && pend[1]) ? 1 - mlast : (pend[1] ? 1 : 0);
                mlast = owner;
                grant_cyc = cyc;
                prev_addr = acc_addr; prev_wd = acc_wd;
                acc_addr = ra[owner]; acc_wd = rd[owner]; acc_w = rw[owner];
                hang = $urandom_range(0, 31) == 0;
                done_cyc = cyc + (hang ? TMO + 1 : int'($urandom_range(1, 4)));
                free_at = done_cyc + 2;
            end
            busy = owner >= 0 && cyc > grant_cyc;
            sc_ready = busy ? (cyc == done_cyc && !hang) : ($urandom_range(0, 3) == 0);
            sc_rdata = $urandom;
            for (int p = 0; p < 2; p++) erdy[p] = !pend[p] || (busy && owner == p && cyc == done_cyc);
            ea = cyc > grant_cyc ? acc_addr : prev_addr;
            ed = cyc > grant_cyc ? acc_wd : prev_wd;
            @(negedge clk);
            chkb("rnd p0_ready", p0_ready, erdy[0]);
            chkb("rnd p1_ready", p1_ready, erdy[1]);
            chkb("rnd sc_r_en", sc_r_en, busy && !acc_w);
            chkb("rnd sc_w_en", sc_w_en, busy && acc_w);
            chkw("rnd sc_addr", sc_addr, ea);
            chkw("rnd sc_wdata", sc_wdata, ed);
            chkw("rnd p0_rdata", p0_rdata, exp_rd[0]);
            chkw("rnd p1_rdata", p1_rdata, exp_rd[1]);
            chkb("rnd err", err, exp_err);
            if (busy && cyc == done_cyc) begin
                if (hang) exp_err = 1;
                else if (!acc_w) exp_rd[owner] = sc_rdata;
                owner = -1;
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        tbl[0] = '{0, 1, 0, 32'h100, 32'h0,        32'hDEADBEEF, 3, 0, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1, 1, 1, 32'h204, 32'h12345678, 32'hFFFFFFFF, 1, 1, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1, 1, 0, 32'h208, 32'h0,        32'hCAFEF00D, 2, 0, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[3] = '{0, 0, 1, 32'h10C, 32'hA5A5A5A5, 32'h77777777, 4, 1, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[4] = '{0, 1, 0, 32'h110, 32'h0,        32'h01020304, 1, 0, 32'h01020304, 32'hCAFEF00D};
        tbl[5] = '{0, 1, 0, 32'h400, 32'h0,        32'h55AA55AA, 2, 0, 32'h55AA55AA, 32'hCAFEF00D};
        do_reset();
        seq_alternate();
        do_reset();
        for (int i = 0; i < 5; i++) run_row(tbl[i]);
        seq_timeout();
        run_row(tbl[5]);
        chkb("err sticky after next access", err, 1);
        seq_midreset();
        do_reset();
        rand_phase(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vecs);
        $fatal(1);
    end
endmodule
